// File: rtl/block_packer_if.sv
// Word-stream and router-issue signals of the block packer, bundled as one interface.
// The slave modport is the packer's view; master is the feeder/router side.
interface block_packer_if;
   logic [31:0]  word_in;
   logic         word_valid;
   logic         word_ready;
   logic         word_last;
   logic         busy;
   logic         d_tk;
   logic [127:0] tk_out;

   modport master (
      output word_in, word_valid, word_last, busy,
      input  word_ready, d_tk, tk_out
   );

   modport slave (
      input  word_in, word_valid, word_last, busy,
      output word_ready, d_tk, tk_out
   );
endinterface

// File: rtl/block_packer.sv
// Packs 32-bit words into 128-bit blocks, buffers them and issues one d_tk strobe per block.
// Optional macro PARTIAL_FLUSH_EN: word_last closes a short, zero-filled block early.
module block_packer #(
   parameter int FIFO_DEPTH = 2,
   parameter int GAP_CYCLES = 1,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   block_packer_if.slave                 bus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic [CNT_W-1:0]              blk_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t         r_state, w_next;
   logic [1:0]     r_idx;
   logic [127:0]   r_blk, w_blk;
   logic [127:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wptr, r_rptr;
   logic [AW:0]    r_cnt;
   logic [127:0]   r_tk;
   logic [CNT_W-1:0] r_blkCnt;
   logic [GW-1:0]  r_gap;
   logic           w_full, w_accept, w_close, w_push, w_pop;
   logic           w_canIssue, w_gapDone, w_dtk, w_load;

   assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));

`ifdef PARTIAL_FLUSH_EN
   assign bus.word_ready = !(w_full && ((r_idx == 2'd3) || (bus.word_valid && bus.word_last)));
   assign w_close        = w_accept && ((r_idx == 2'd3) || bus.word_last);
`else
   assign bus.word_ready = !(w_full && (r_idx == 2'd3));
   assign w_close        = w_accept && (r_idx == 2'd3);
`endif

   assign w_accept = bus.word_valid && bus.word_ready;
   assign w_push   = w_close;
   assign w_pop    = (r_state == ISSUE);

   // r_blk is cleared after every push, so unwritten lower words of a flushed block read as zero
   always_comb begin
      w_blk = r_blk;
      case (r_idx)
         2'd0:    w_blk[127:96] = bus.word_in;
         2'd1:    w_blk[95:64]  = bus.word_in;
         2'd2:    w_blk[63:32]  = bus.word_in;
         default: w_blk[31:0]   = bus.word_in;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx <= 2'd0;
         r_blk <= '0;
      end else if (w_accept) begin
         if (w_close) begin
            r_idx <= 2'd0;
            r_blk <= '0;
         end else begin
            r_idx <= r_idx + 2'd1;
            r_blk <= w_blk;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_blk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign w_canIssue = (r_cnt != '0) && !bus.busy;
   assign w_gapDone  = (r_gap == GW'(GAP_CYCLES - 1));

   // The last gap cycle doubles as the idle decision cycle, so back-to-back issues sit
   // exactly GAP_CYCLES idle cycles apart.
   always_comb begin
      w_next = r_state;
      w_dtk  = 1'b0;
      w_load = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_canIssue) begin
               w_next = ISSUE;
               w_load = 1'b1;
            end
         end
         ISSUE: begin
            w_dtk  = !rst;
            w_next = GAP;
         end
         GAP: begin
            if (w_gapDone) begin
               if (w_canIssue) begin
                  w_next = ISSUE;
                  w_load = 1'b1;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_gap    <= '0;
         r_tk     <= '0;
         r_blkCnt <= '0;
      end else begin
         r_state <= w_next;
         r_gap   <= (r_state == GAP) ? r_gap + 1'b1 : '0;
         if (w_load) r_tk     <= r_mem[r_rptr];
         if (w_pop)  r_blkCnt <= r_blkCnt + 1'b1;
      end
   end

   assign bus.d_tk   = w_dtk;
   assign bus.tk_out = r_tk;
   assign fifo_cnt   = r_cnt;
   assign blk_count  = r_blkCnt;
endmodule

// File: doc/block_packer.md
Name: block_packer

Overview:
- Upstream feeder for the multi-core AES data router.
- Accepts a stream of 32-bit plaintext words with a valid/ready handshake and packs each group of 4 words into one 128-bit block.
- Buffers completed blocks in a small FIFO.
- Issues each block to the router as a one-cycle d_tk strobe with data held on tk_out, only while the router is not busy.

Parameters:
- FIFO_DEPTH, 2: number of completed 128-bit blocks buffered; power of 2, ≥2.
- GAP_CYCLES, 1: minimum idle cycles between successive d_tk pulses, so the router's edge detector sees distinct edges; ≥1.
- CNT_W, 16: width of the issued-block counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- word_in  input  32  plaintext word.
- word_valid  input  1  word_in valid.
- word_ready  output  1  packer can accept word_in this cycle.
- word_last  input  1  marks final word of a message (used only with PARTIAL_FLUSH_EN).
- busy  input  1  router has no free AES core; no issue while high.
- d_tk  output  1  one-cycle strobe: new block on tk_out.
- tk_out  output  128  block presented to router.
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  blocks currently buffered.
- blk_count  output  CNT_W  total blocks issued, wraps modulo 2^CNT_W.

Behaviour:
- Reset: one clock is the only clock; rst is synchronous and active-high. All state clears on a rising clk edge with rst=1. After reset: word_ready=1, d_tk=0, tk_out=0, fifo_cnt=0, blk_count=0, word index=0, FSM=IDLE.
- Reset mid-operation: discards the partial block and all FIFO contents; no d_tk is produced in the reset cycle.
- Word accept: a word is accepted when word_valid && word_ready.
- Packing order: first word goes to bits [127:96], second to [95:64], third to [63:32], fourth to [31:0].
- Word index: 2-bit index, increments on each accept and wraps 3→0.
- Block push: accepting the 4th word pushes the assembled block into the FIFO on the same edge; fifo_cnt reflects it the next cycle.
- word_ready: registered-style, with no combinational path from busy. word_ready = !(fifo_full && index==3).
  - Words 0–2 are always accepted, even while the FIFO is full.
  - Push while full is never possible.
- Issue FSM states:
  - IDLE: if fifo_cnt>0 and busy==0, go to ISSUE.
  - ISSUE (one cycle): d_tk=1; tk_out loads the FIFO head on entry and holds until the next issue; FIFO pops; blk_count+1. Then go to GAP.
  - GAP: gap counter counts GAP_CYCLES cycles with d_tk=0, then returns to IDLE. The next issue can therefore occur no earlier than GAP_CYCLES+1 cycles after the previous d_tk.
- Issue latency: 4th word accepted at edge N → block in FIFO at N+1 → d_tk high during cycle N+2 if IDLE and busy=0.
- busy sampling: busy is sampled only in IDLE. busy rising during ISSUE or GAP does not cancel that issue.
- Simultaneous push and pop: both take effect on the same edge; fifo_cnt is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Empty FIFO: stays in IDLE with d_tk=0 regardless of busy.
- blk_count: wraps from 2^CNT_W-1 to 0 without any flag.

Optional Feature:
- Macro: PARTIAL_FLUSH_EN.
- Defined: word_last accepted with index<3 closes the current block immediately.
  - Remaining lower words are zero-filled.
  - The block is pushed and the index resets to 0.
  - word_ready also deasserts when fifo_full && word_valid && word_last, so a flush is never dropped.
  - word_last with index==3 behaves as a normal 4th word.
- Not defined: word_last is ignored; blocks are emitted only on every 4th word.

Test Plan:
- Reset, then 4 words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with busy=0 → d_tk pulses exactly once, 2 cycles after the 4th accept; tk_out=0x00112233445566778899AABBCCDDEEFF; blk_count=1.
- busy=1 held, 12 words streamed → fifo_cnt reaches 2; word_ready=0 when index=3 with 2 blocks buffered; release busy → two d_tk pulses separated by exactly GAP_CYCLES idle cycles, in arrival order; the third block then enters.
- Push and pop in the same cycle with fifo_cnt=1 → fifo_cnt stays 1; no data lost or duplicated across 8 blocks.
- rst asserted after 2 words and 1 buffered block → next cycle fifo_cnt=0, d_tk=0, tk_out=0; the next 4 words form a clean block.
- PARTIAL_FLUSH_EN: words 0xAAAAAAAA, 0xBBBBBBBB with word_last on the 2nd → tk_out=0xAAAAAAAABBBBBBBB0000000000000000. Without the macro: no d_tk until 2 more words arrive.
- CNT_W=4 override, issue 17 blocks → blk_count=1 after the wrap.
